relay_gain_sequencer: RTL and testbench

Sequences the two latching gain-select relays in the ADC front end. It accepts gain-change requests from the automatic gain controller and drives break-before-make coil pulses. It holds off further changes through a settle interval and an optional minimum dwell interval. It reports when the analog path is usable again and forces the relays into a known state after reset.

---
 rtl/relay_gain_sequencer_if.sv | 18 +
 rtl/relay_gain_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_relay_gain_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/relay_gain_sequencer_if.sv
// Gain-request handshake between the AGC (master) and the relay sequencer.
interface relay_gain_sequencer_if;
    logic       req_valid;
    logic [1:0] req_gain;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_gain,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_gain,
        output req_ready
    );
endinterface

// File: rtl/relay_gain_sequencer.sv
// Break-before-make sequencer for the two latching ADC gain relays.
// Optional minimum dwell after settle: define RELAY_DWELL_EN.
module relay_gain_sequencer #(
    parameter int PULSE_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int DWELL_CYCLES  = 256,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    relay_gain_sequencer_if.slave   req,
    output logic [1:0]              coil_set,
    output logic [1:0]              coil_rst,
    output logic [1:0]              gain_state,
    output logic                    settled,
    output logic                    busy,
    output logic [7:0]              switch_count
);

    typedef enum logic [2:0] {
        INIT_RST,
        INIT_SET,
        DRIVE_RST,
        DRIVE_SET,
        SETTLE,
        DWELL,
        IDLE
    } state_t;

`ifdef RELAY_DWELL_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] D_LD = CNT_W'(DWELL_CYCLES - 1);
    // Reset period counts as an extra INIT_RST cycle, so load one more.
    localparam logic [CNT_W-1:0] P_RST = CNT_W'(PULSE_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       target_q, target_d;
    logic [1:0]       fall_q, fall_d;
    logic [1:0]       rise_q, rise_d;
    logic             init_q, init_d;
    logic [1:0]       gain_q, gain_d;
    logic [7:0]       count_q, count_d;
    logic [1:0]       coil_set_q, coil_set_d;
    logic [1:0]       coil_rst_q, coil_rst_d;
    logic             settled_q, settled_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             cnt_done;

    assign cnt_done = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q - CNT_W'(1);
        target_d = target_q;
        fall_d   = fall_q;
        rise_d   = rise_q;
        init_d   = init_q;
        gain_d   = gain_q;
        count_d  = count_q;

        unique case (state_q)
            INIT_RST: begin
                if (cnt_done) begin
                    state_d = INIT_SET;
                    cnt_d   = P_LD;
                end
            end
            INIT_SET: begin
                if (cnt_done) begin
                    state_d = SETTLE;
                    cnt_d   = S_LD;
                end
            end
            DRIVE_RST: begin
                if (cnt_done) begin
                    if (rise_q != 2'b00) begin
                        state_d = DRIVE_SET;
                        cnt_d   = P_LD;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = S_LD;
                        gain_d  = target_q;
                        count_d = count_q + 8'd1;
                    end
                end
            end
            DRIVE_SET: begin
                if (cnt_done) begin
                    state_d = SETTLE;
                    cnt_d   = S_LD;
                    gain_d  = target_q;
                    count_d = count_q + 8'd1;
                end
            end
            SETTLE: begin
                if (cnt_done) begin
                    init_d = 1'b0;
                    if (DWELL_EN && !init_q) begin
                        state_d = DWELL;
                        cnt_d   = D_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DWELL: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = cnt_q;
                if (req.req_valid) begin
                    target_d = req.req_gain;
                    fall_d   = gain_q & ~req.req_gain;
                    rise_d   = ~gain_q & req.req_gain;
                    if (req.req_gain != gain_q) begin
                        cnt_d   = P_LD;
                        state_d = (fall_d != 2'b00) ? DRIVE_RST
                                                    : DRIVE_SET;
                    end
                end
            end
            default: begin
                state_d = INIT_RST;
                cnt_d   = P_RST;
                init_d  = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered.
    always_comb begin
        coil_set_d = 2'b00;
        coil_rst_d = 2'b00;
        unique case (state_d)
            INIT_RST:  coil_rst_d = 2'b11;
            INIT_SET:  coil_set_d = 2'b11;
            DRIVE_RST: coil_rst_d = fall_d;
            DRIVE_SET: coil_set_d = rise_d;
            default:   ;
        endcase
        settled_d = (state_d == IDLE) || (state_d == DWELL);
        ready_d   = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT_RST;
            cnt_q      <= P_RST;
            target_q   <= 2'b11;
            fall_q     <= 2'b00;
            rise_q     <= 2'b00;
            init_q     <= 1'b1;
            gain_q     <= 2'b11;
            count_q    <= 8'd0;
            coil_set_q <= 2'b00;
            coil_rst_q <= 2'b00;
            settled_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            fall_q     <= fall_d;
            rise_q     <= rise_d;
            init_q     <= init_d;
            gain_q     <= gain_d;
            count_q    <= count_d;
            coil_set_q <= coil_set_d;
            coil_rst_q <= coil_rst_d;
            settled_q  <= settled_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign coil_set      = coil_set_q;
    assign coil_rst      = coil_rst_q;
    assign gain_state    = gain_q;
    assign settled       = settled_q;
    assign busy          = busy_q;
    assign switch_count  = count_q;
    assign req.req_ready = ready_q;

endmodule

// File: tb/tb_relay_gain_sequencer.sv
// Directed bench for relay_gain_sequencer (default P=16, S=64, D=256).
// Expected timing follows RELAY_DWELL_EN in the same way as the design.
module tb_relay_gain_sequencer;

    localparam int P = 16;
    localparam int S = 64;
`ifdef RELAY_DWELL_EN
    localparam int DW = 256;
`else
    localparam int DW = 0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] coil_set;
    logic [1:0] coil_rst;
    logic [1:0] gain_state;
    logic       settled;
    logic       busy;
    logic [7:0] switch_count;

    int errors = 0;
    int checks = 0;

    relay_gain_sequencer_if rif ();

    relay_gain_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .req          (rif),
        .coil_set     (coil_set),
        .coil_rst     (coil_rst),
        .gain_state   (gain_state),
        .settled      (settled),
        .busy         (busy),
        .switch_count (switch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic init_trace(input string tag);
        logic [1:0] e_cr, e_cs;
        logic       e_st;
        for (int c = 1; c <= 2*P + S + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            e_cr = (c <= P) ? 2'b11 : 2'b00;
            e_cs = (c > P && c <= 2*P) ? 2'b11 : 2'b00;
            e_st = (c >= 2*P + S + 1);
            checks++;
            if ({coil_rst, coil_set, gain_state, settled,
                 rif.req_ready, busy, switch_count} !==
                {e_cr, e_cs, 2'b11, e_st, e_st, !e_st, 8'd0}) begin
                errors++;
                $display("FAIL %s cyc=%0d got cr=%b cs=%b g=%b st=%b rdy=%b bsy=%b n=%0d exp cr=%b cs=%b g=11 st=%b rdy=%b bsy=%b n=0",
                         tag, c, coil_rst, coil_set, gain_state,
                         settled, rif.req_ready, busy, switch_count,
                         e_cr, e_cs, e_st, e_st, !e_st);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rif.req_valid = 1'b0;
        rif.req_gain  = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({coil_rst, coil_set, gain_state, settled,
             rif.req_ready, busy, switch_count} !==
            {2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_values got cr=%b cs=%b g=%b st=%b rdy=%b bsy=%b n=%0d exp 00 00 11 0 0 1 0",
                     coil_rst, coil_set, gain_state, settled,
                     rif.req_ready, busy, switch_count);
        end
        rst = 1'b0;
        init_trace("reset_init");
    endtask

    // 11 -> 10: reset phase only, set phase skipped
    task automatic test_single_phase();
        logic [1:0] e_cr, e_g;
        logic       e_st, e_rdy;
        logic [7:0] e_n;
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_gain  = 2'b10;
        for (int c = 1; c <= P + S + DW + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) rif.req_valid = 1'b0;
            e_cr  = (c <= P) ? 2'b01 : 2'b00;
            e_g   = (c >= P + 1) ? 2'b10 : 2'b11;
            e_n   = (c >= P + 1) ? 8'd1 : 8'd0;
            e_st  = (c >= P + S + 1);
            e_rdy = (c >= P + S + DW + 1);
            checks++;
            if ({coil_rst, coil_set, gain_state, settled,
                 rif.req_ready, busy, switch_count} !==
                {e_cr, 2'b00, e_g, e_st, e_rdy, !e_rdy, e_n}) begin
                errors++;
                $display("FAIL single_phase cyc=%0d got cr=%b cs=%b g=%b st=%b rdy=%b bsy=%b n=%0d exp cr=%b cs=00 g=%b st=%b rdy=%b bsy=%b n=%0d",
                         c, coil_rst, coil_set, gain_state, settled,
                         rif.req_ready, busy, switch_count,
                         e_cr, e_g, e_st, e_rdy, !e_rdy, e_n);
            end
        end
    endtask

    // 10 -> 01: both phases, break before make
    task automatic test_two_phase();
        logic [1:0] e_cr, e_cs, e_g;
        logic       e_st, e_rdy;
        logic [7:0] e_n;
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_gain  = 2'b01;
        for (int c = 1; c <= 2*P + S + DW + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) rif.req_valid = 1'b0;
            e_cr  = (c <= P) ? 2'b10 : 2'b00;
            e_cs  = (c > P && c <= 2*P) ? 2'b01 : 2'b00;
            e_g   = (c >= 2*P + 1) ? 2'b01 : 2'b10;
            e_n   = (c >= 2*P + 1) ? 8'd2 : 8'd1;
            e_st  = (c >= 2*P + S + 1);
            e_rdy = (c >= 2*P + S + DW + 1);
            checks++;
            if ({coil_rst, coil_set, gain_state, settled,
                 rif.req_ready, busy, switch_count} !==
                {e_cr, e_cs, e_g, e_st, e_rdy, !e_rdy, e_n}) begin
                errors++;
                $display("FAIL two_phase cyc=%0d got cr=%b cs=%b g=%b st=%b rdy=%b bsy=%b n=%0d exp cr=%b cs=%b g=%b st=%b rdy=%b bsy=%b n=%0d",
                         c, coil_rst, coil_set, gain_state, settled,
                         rif.req_ready, busy, switch_count,
                         e_cr, e_cs, e_g, e_st, e_rdy, !e_rdy, e_n);
            end
            checks++;
            if ((coil_rst & coil_set) !== 2'b00) begin
                errors++;
                $display("FAIL coil_overlap cyc=%0d got cr=%b cs=%b exp disjoint",
                         c, coil_rst, coil_set);
            end
        end
    endtask

    task automatic test_same_gain();
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_gain  = 2'b01;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({coil_rst, coil_set, gain_state, settled,
                 rif.req_ready, busy, switch_count} !==
                {2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 8'd2}) begin
                errors++;
                $display("FAIL same_gain cyc=%0d got cr=%b cs=%b g=%b st=%b rdy=%b bsy=%b n=%0d exp 00 00 01 1 1 0 2",
                         c, coil_rst, coil_set, gain_state, settled,
                         rif.req_ready, busy, switch_count);
            end
        end
        rif.req_valid = 1'b0;
    endtask

    // 01 -> 11 with valid held; code changes while busy, then 11 -> 00
    task automatic test_back_to_back();
        int         r;
        bit         seen;
        logic [1:0] e_cr, e_cs, e_g;
        logic       e_rdy;
        logic [7:0] e_n;
        r = P + S + DW + 1;
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_gain  = 2'b11;
        for (int c = 1; c <= r + P + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1)     rif.req_gain  = 2'b10;
            if (c == 40)    rif.req_gain  = 2'b00;
            if (c == r + 1) rif.req_valid = 1'b0;
            e_cs  = (c <= P) ? 2'b10 : 2'b00;
            e_cr  = (c > r && c <= r + P) ? 2'b11 : 2'b00;
            e_g   = (c <= P) ? 2'b01 :
                    (c <= r + P) ? 2'b11 : 2'b00;
            e_n   = (c <= P) ? 8'd2 :
                    (c <= r + P) ? 8'd3 : 8'd4;
            e_rdy = (c == r);
            checks++;
            if ({coil_rst, coil_set, gain_state, rif.req_ready,
                 switch_count} !==
                {e_cr, e_cs, e_g, e_rdy, e_n}) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got cr=%b cs=%b g=%b rdy=%b n=%0d exp cr=%b cs=%b g=%b rdy=%b n=%0d",
                         c, coil_rst, coil_set, gain_state,
                         rif.req_ready, switch_count,
                         e_cr, e_cs, e_g, e_rdy, e_n);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            seen = rif.req_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_return_idle got rdy=0 exp rdy=1 within 2000 cycles");
        end
    endtask

    // 00 -> 11 (set phase only), reset pulsed mid-pulse
    task automatic test_reset_mid_drive();
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_gain  = 2'b11;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) rif.req_valid = 1'b0;
        end
        checks++;
        if ({coil_rst, coil_set, busy} !== {2'b00, 2'b11, 1'b1}) begin
            errors++;
            $display("FAIL drive_set_active got cr=%b cs=%b bsy=%b exp 00 11 1",
                     coil_rst, coil_set, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({coil_rst, coil_set, gain_state, settled,
             rif.req_ready, busy, switch_count} !==
            {2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL async_reset got cr=%b cs=%b g=%b st=%b rdy=%b bsy=%b n=%0d exp 00 00 11 0 0 1 0",
                     coil_rst, coil_set, gain_state, settled,
                     rif.req_ready, busy, switch_count);
        end
        @(negedge clk);
        rst = 1'b0;
        init_trace("rerun_init");
    endtask

    initial begin
        test_reset();
        test_single_phase();
        test_two_phase();
        test_same_gain();
        test_back_to_back();
        test_reset_mid_drive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
